eth_tx_pkt_buf: RTL

Store-and-forward packet buffer between the application and eth_tx, parametrised in data width, buffer depth and number of queued packets. It accepts application beats of arbitrary packet length and commits each complete packet to a descriptor queue. It then replays the packet to eth_tx with the total byte length (app_pkt_len) and the UDP payload checksum known from the first output beat, which eth_tx needs to build its IP/UDP header up front.

---
 rtl/eth_tx_pkt_buf_pkg.sv | 26 ++
 rtl/eth_tx_pkt_buf_cs.sv | 42 ++++
 rtl/eth_tx_pkt_buf.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkt_buf_pkg.sv
// Shared types for the eth_tx store-and-forward packet buffer.
// ETH_TX_PKT_BUF_CS_EN adds the payload checksum field to the descriptor.
package eth_tx_pkt_buf_pkg;

  localparam int DESC_LEN_W = 16;

  typedef struct packed {
    logic [DESC_LEN_W-1:0] pkt_len;
`ifdef ETH_TX_PKT_BUF_CS_EN
    logic [15:0]           cs;
`endif
  } desc_t;

  typedef enum logic {IN_ACC, IN_DISCARD} in_state_e;

  typedef enum logic [1:0] {OUT_IDLE, OUT_LOAD, OUT_SEND} out_state_e;

  // 16-bit one's-complement add; a single fold is enough because the
  // low half is at most 0xFFFE whenever the carry is set.
  function automatic logic [15:0] cs_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/eth_tx_pkt_buf_cs.sv
// Per-beat UDP payload checksum accumulator. sum_o already includes the
// current beat so the last beat of a packet can be committed without a
// cycle of delay; the register only advances on en.
module eth_tx_pkt_buf_cs
  import eth_tx_pkt_buf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  len,
  output logic [15:0]       sum_o
);
  localparam int WORDS = DATA_W / 16;

  logic [15:0] sum_q;
  logic [7:0]  hi, lo;

  // fold each big-endian byte pair of the beat into the running sum
  always_comb begin
    sum_o = sum_q;
    hi    = 8'h00;
    lo    = 8'h00;
    for (int j = 0; j < WORDS; j++) begin
      hi    = (int'(len) > 2*j)     ? data[16*j +: 8]   : 8'h00;
      lo    = (int'(len) > 2*j + 1) ? data[16*j+8 +: 8] : 8'h00;
      sum_o = cs_add16(sum_o, {hi, lo});
    end
  end

  // running sum register, cleared at every packet boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sum_q <= '0;
    else if (clr) sum_q <= '0;
    else if (en)  sum_q <= sum_o;
  end

endmodule

// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward TX packet buffer: packets are accumulated in a beat RAM,
// committed to a descriptor FIFO on their last beat, then replayed with
// length (and checksum when ETH_TX_PKT_BUF_CS_EN is defined) known up front.
module eth_tx_pkt_buf
  import eth_tx_pkt_buf_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int LEN_W     = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W = 16,
  parameter int DEPTH     = 64,
  parameter int PKT_N     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_W-1:0]    in_data_i,
  input  logic [LEN_W-1:0]     in_len_i,
  input  logic                 in_last_i,
  input  logic                 in_cancel_i,
  output logic                 app_valid_o,
  input  logic                 app_ready_i,
  output logic [DATA_W-1:0]    app_data_o,
  output logic [LEN_W-1:0]     app_len_o,
  output logic                 app_last_o,
  output logic [PKT_LEN_W-1:0] app_pkt_len_o,
  output logic [15:0]          app_cs_o,
  output logic                 drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PKT_N);
  localparam int RW = DATA_W + LEN_W + 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [PW:0] DSC_ONE = (PW+1)'(1);

  logic [RW-1:0]        ram [DEPTH];
  logic [RW-1:0]        rd_q;
  logic [AW:0]          wr_ptr, wr_ptr_nxt, commit_ptr, commit_ptr_nxt, rd_ptr;
  logic [AW:0]          beat_cnt, beat_cnt_nxt;
  logic [PKT_LEN_W-1:0] pkt_len, pkt_len_nxt, len_sum;
  desc_t                desc_mem [PKT_N];
  desc_t                desc_in, desc_rd, cur_desc;
  logic [PW:0]          desc_wp, desc_rp, desc_cnt, desc_idx;
  in_state_e            in_state, in_state_nxt;
  out_state_e           out_state, out_state_nxt;
  logic                 rst_done, ram_full, desc_full, desc_empty, in_acc;
  logic                 ram_we, commit, drop_nxt, beat_adv;
  logic                 rd_en, pop, load_desc;

  // uncommitted beats count against the read pointer, so a half-written
  // packet also holds back the writer
  assign ram_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign desc_cnt    = desc_wp - desc_rp;
  assign desc_full   = (desc_cnt == (PW+1)'(PKT_N));
  assign desc_empty  = (desc_cnt == '0);
  assign in_ready_o  = rst_done && !ram_full && !desc_full;
  assign in_acc      = in_valid_i && in_ready_o;
  assign len_sum     = pkt_len + PKT_LEN_W'(in_len_i);

  assign app_valid_o   = (out_state == OUT_SEND);
  assign app_data_o    = rd_q[RW-1 -: DATA_W];
  assign app_len_o     = rd_q[LEN_W:1];
  assign app_last_o    = rd_q[0];
  assign app_pkt_len_o = PKT_LEN_W'(cur_desc.pkt_len);

`ifdef ETH_TX_PKT_BUF_CS_EN
  logic [15:0] cs_sum;

  eth_tx_pkt_buf_cs #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_cs (
    .clk   (clk),
    .reset (reset),
    .clr   (drop_nxt || commit),
    .en    (beat_adv),
    .data  (in_data_i),
    .len   (in_len_i),
    .sum_o (cs_sum)
  );
  assign app_cs_o = cur_desc.cs;
`else
  assign app_cs_o = 16'h0;
`endif

  // descriptor for the packet being committed this cycle
  always_comb begin
    desc_in         = '0;
    desc_in.pkt_len = DESC_LEN_W'(len_sum);
`ifdef ETH_TX_PKT_BUF_CS_EN
    desc_in.cs      = cs_sum;
`endif
  end

  // input FSM: accumulate, commit on last beat, or drop and rewind
  always_comb begin
    in_state_nxt   = in_state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    pkt_len_nxt    = pkt_len;
    beat_cnt_nxt   = beat_cnt;
    ram_we         = 1'b0;
    commit         = 1'b0;
    drop_nxt       = 1'b0;
    beat_adv       = 1'b0;
    if (in_cancel_i) begin
      drop_nxt     = 1'b1;
      in_state_nxt = IN_ACC;
    end else if (in_acc) begin
      if (in_state == IN_ACC) begin
        ram_we = 1'b1;
        if (in_last_i) begin
          if (len_sum == '0) drop_nxt = 1'b1;
          else begin
            commit         = 1'b1;
            wr_ptr_nxt     = wr_ptr + PTR_ONE;
            commit_ptr_nxt = wr_ptr + PTR_ONE;
          end
        // a non-last beat filling the RAM means the packet can never fit
        end else if (in_len_i != LEN_W'(KEEP_W) || beat_cnt == (AW+1)'(DEPTH-1)) begin
          drop_nxt     = 1'b1;
          in_state_nxt = IN_DISCARD;
        end else begin
          beat_adv     = 1'b1;
          wr_ptr_nxt   = wr_ptr + PTR_ONE;
          pkt_len_nxt  = len_sum;
          beat_cnt_nxt = beat_cnt + PTR_ONE;
        end
      end else if (in_last_i) begin
        in_state_nxt = IN_ACC;
      end
    end
    if (drop_nxt) wr_ptr_nxt = commit_ptr;
    if (drop_nxt || commit) begin
      pkt_len_nxt  = '0;
      beat_cnt_nxt = '0;
    end
  end

  // input side state, pointers and descriptor write pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state   <= IN_ACC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pkt_len    <= '0;
      beat_cnt   <= '0;
      desc_wp    <= '0;
      drop_o     <= 1'b0;
      rst_done   <= 1'b0;
    end else begin
      in_state   <= in_state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      pkt_len    <= pkt_len_nxt;
      beat_cnt   <= beat_cnt_nxt;
      drop_o     <= drop_nxt;
      rst_done   <= 1'b1;
      if (commit) desc_wp <= desc_wp + DSC_ONE;
    end
  end

  // beat and descriptor storage, no reset needed
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr[AW-1:0]] <= {in_data_i, in_len_i, in_last_i};
    if (commit) desc_mem[desc_wp[PW-1:0]] <= desc_in;
  end

  // on a last-beat pop the next descriptor sits one slot further on
  assign desc_idx = pop ? desc_rp + DSC_ONE : desc_rp;
  assign desc_rd  = desc_mem[desc_idx[PW-1:0]];

  // output FSM: the next RAM read is issued on each handshake so beats
  // stream without gaps while app_ready_i stays high
  always_comb begin
    out_state_nxt = out_state;
    rd_en         = 1'b0;
    pop           = 1'b0;
    load_desc     = 1'b0;
    case (out_state)
      OUT_IDLE: if (!desc_empty) begin
        rd_en         = 1'b1;
        load_desc     = 1'b1;
        out_state_nxt = OUT_LOAD;
      end
      OUT_LOAD: out_state_nxt = OUT_SEND;
      OUT_SEND: if (app_ready_i) begin
        if (!app_last_o) rd_en = 1'b1;
        else begin
          pop = 1'b1;
          if (desc_cnt > DSC_ONE) begin
            rd_en         = 1'b1;
            load_desc     = 1'b1;
            out_state_nxt = OUT_LOAD;
          end else begin
            out_state_nxt = OUT_IDLE;
          end
        end
      end
      default: out_state_nxt = OUT_IDLE;
    endcase
  end

  // output side state, read pointer, read register and current descriptor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= OUT_IDLE;
      rd_ptr    <= '0;
      rd_q      <= '0;
      cur_desc  <= '0;
      desc_rp   <= '0;
    end else begin
      out_state <= out_state_nxt;
      if (rd_en) begin
        rd_q   <= ram[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (load_desc) cur_desc <= desc_rd;
      if (pop) desc_rp <= desc_rp + DSC_ONE;
    end
  end

endmodule
